// File: rtl/led_chain_driver_if.sv
// Request and LED-chain signal bundle for led_chain_driver.
// The master side issues frames; the slave side drives the serial chain.
interface led_chain_driver_if #(
   parameter int N_BITS   = 16,
   parameter int PWM_BITS = 8
);
   logic                start;
   logic [N_BITS-1:0]   data;
   logic [PWM_BITS-1:0] brightness;
   logic                ready;
   logic                done;
   logic                sdi;
   logic                sclk;
   logic                latch;
   logic                n_output_enable;

   modport master (
      output start, data, brightness,
      input  ready, done, sdi, sclk, latch, n_output_enable
   );

   modport slave (
      input  start, data, brightness,
      output ready, done, sdi, sclk, latch, n_output_enable
   );
endinterface

// File: rtl/led_chain_driver.sv
// Serialises a frame into an LED driver chain (sdi/sclk/latch) and dims the
// chain with a free-running PWM on n_output_enable.
module led_chain_driver #(
   parameter int N_BITS      = 16,
   parameter int HALF_PERIOD = 2,
   parameter int PWM_BITS    = 8
) (
   input  logic              CLOCK_5,
   input  logic              reset,
   led_chain_driver_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] HIGH  = 2'd2;
   localparam logic [1:0] LATCH = 2'd3;

   localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam int HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_BITS - 1);
   localparam logic [HP_W-1:0]  HP_TOP  = HP_W'(HALF_PERIOD - 1);

   logic [1:0]          state_reg, state_next;
   logic [HP_W-1:0]     hp_cnt_reg, hp_cnt_next;
   logic [IDX_W-1:0]    bit_idx_reg, bit_idx_next;
   logic [N_BITS-1:0]   data_shadow_reg, data_shadow_next;
   logic [PWM_BITS-1:0] bright_shadow_reg, bright_shadow_next;
   logic [PWM_BITS-1:0] duty_reg, duty_next;
   logic [PWM_BITS-1:0] pwm_cnt_reg, pwm_cnt_next;
   logic                display_valid_reg, display_valid_next;
   logic                ready_reg, ready_next;
   logic                done_reg, done_next;
   logic                sdi_reg, sdi_next;
   logic                sclk_reg, sclk_next;
   logic                latch_reg, latch_next;
   logic                noe_reg, noe_next;
   logic                accept;
   logic                hp_expired;
   logic                latch_exit;

   always_comb begin
      hp_expired         = (hp_cnt_reg == '0);
      accept             = ready_reg && bus.start;
      latch_exit         = (state_reg == LATCH) && hp_expired;
      state_next         = state_reg;
      hp_cnt_next        = hp_expired ? HP_TOP : hp_cnt_reg - 1'b1;
      bit_idx_next       = bit_idx_reg;
      data_shadow_next   = data_shadow_reg;
      bright_shadow_next = bright_shadow_reg;

      case (state_reg)
         SETUP: if (hp_expired) state_next = HIGH;
         HIGH: begin
            if (hp_expired) begin
               if (bit_idx_reg != '0) begin
                  bit_idx_next = bit_idx_reg - 1'b1;
                  state_next   = SETUP;
               end else begin
                  state_next = LATCH;
               end
            end
         end
         LATCH:   if (hp_expired) state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // ready is also high in the final LATCH cycle, so a new frame can start on the exit edge
      if (accept) begin
         state_next         = SETUP;
         hp_cnt_next        = HP_TOP;
         bit_idx_next       = IDX_TOP;
         data_shadow_next   = bus.data;
         bright_shadow_next = bus.brightness;
      end

      // Outputs are derived from the next state so they register in step with it
      latch_next = (state_next == LATCH);
      sclk_next  = (state_next == HIGH);
      sdi_next   = ((state_next == SETUP) || (state_next == HIGH)) ?
                   data_shadow_next[bit_idx_next] : 1'b0;
      done_next  = latch_next && (hp_cnt_next == '0);
      ready_next = (state_next == IDLE) || done_next;

      duty_next          = latch_exit ? bright_shadow_reg : duty_reg;
      display_valid_next = display_valid_reg || latch_exit;
      pwm_cnt_next       = pwm_cnt_reg + 1'b1;
      noe_next           = !(display_valid_next && (pwm_cnt_next < duty_next));
   end

   always_ff @(posedge CLOCK_5) begin
      if (reset) begin
         state_reg         <= IDLE;
         hp_cnt_reg        <= '0;
         bit_idx_reg       <= '0;
         data_shadow_reg   <= '0;
         bright_shadow_reg <= '0;
         duty_reg          <= '0;
         pwm_cnt_reg       <= '0;
         display_valid_reg <= 1'b0;
         ready_reg         <= 1'b1;
         done_reg          <= 1'b0;
         sdi_reg           <= 1'b0;
         sclk_reg          <= 1'b0;
         latch_reg         <= 1'b0;
         noe_reg           <= 1'b1;
      end else begin
         state_reg         <= state_next;
         hp_cnt_reg        <= hp_cnt_next;
         bit_idx_reg       <= bit_idx_next;
         data_shadow_reg   <= data_shadow_next;
         bright_shadow_reg <= bright_shadow_next;
         duty_reg          <= duty_next;
         pwm_cnt_reg       <= pwm_cnt_next;
         display_valid_reg <= display_valid_next;
         ready_reg         <= ready_next;
         done_reg          <= done_next;
         sdi_reg           <= sdi_next;
         sclk_reg          <= sclk_next;
         latch_reg         <= latch_next;
         noe_reg           <= noe_next;
      end
   end

   assign bus.ready           = ready_reg;
   assign bus.done            = done_reg;
   assign bus.sdi             = sdi_reg;
   assign bus.sclk            = sclk_reg;
   assign bus.latch           = latch_reg;
   assign bus.n_output_enable = noe_reg;
endmodule

// File: tb/tb_led_chain_driver.sv
// Bench for led_chain_driver: directed and random frames against a cycle-indexed
// reference of the frame timing and the PWM dimming rule.
module tb_led_chain_driver;
   localparam int N         = 8;
   localparam int HP        = 2;
   localparam int PW        = 4;
   localparam int FRAME     = (2 * N + 1) * HP;
   localparam int SHIFT_CYC = 2 * N * HP;

   logic CLOCK_5 = 1'b0;
   logic reset   = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // reference model state
   bit            m_active = 1'b0;
   int            m_acc    = 0;
   logic [N-1:0]  m_data   = '0;
   logic [PW-1:0] m_bright = '0;
   int            pwm      = 0;
   int            duty     = 0;
   bit            valid    = 1'b0;

   // observation counters
   int           rises     = 0;
   int           latches   = 0;
   int           dones     = 0;
   logic [N-1:0] sdi_sh    = '0;
   logic         sclk_prev = 1'b0;

   led_chain_driver_if #(.N_BITS(N), .PWM_BITS(PW)) bus ();

   led_chain_driver #(
      .N_BITS(N),
      .HALF_PERIOD(HP),
      .PWM_BITS(PW)
   ) dut (
      .CLOCK_5(CLOCK_5),
      .reset(reset),
      .bus(bus)
   );

   always #5 CLOCK_5 = ~CLOCK_5;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock: update the model on the rising edge, check on the falling edge.
   task automatic tick();
      int   j;
      logic e_sclk, e_sdi, e_latch, e_ready, e_done, e_noe;
      @(posedge CLOCK_5);
      cyc++;
      if (reset) begin
         m_active = 1'b0;
         pwm      = 0;
         duty     = 0;
         valid    = 1'b0;
         chk_en   = 1'b1;
      end else begin
         pwm = (pwm + 1) % (1 << PW);
         if (m_active && (cyc - m_acc == FRAME)) begin
            duty     = int'(m_bright);
            valid    = 1'b1;
            m_active = 1'b0;
         end
         if (bus.start && !m_active) begin
            m_active = 1'b1;
            m_acc    = cyc;
            m_data   = bus.data;
            m_bright = bus.brightness;
         end
      end
      @(negedge CLOCK_5);
      if (chk_en) begin
         e_sclk  = 1'b0;
         e_sdi   = 1'b0;
         e_latch = 1'b0;
         e_ready = 1'b1;
         e_done  = 1'b0;
         if (m_active) begin
            j       = cyc - m_acc;
            e_ready = (j == FRAME - 1);
            e_done  = e_ready;
            if (j < SHIFT_CYC) begin
               e_sclk = ((j % (2 * HP)) >= HP);
               e_sdi  = m_data[N - 1 - j / (2 * HP)];
            end else begin
               e_latch = 1'b1;
            end
         end
         e_noe = !(valid && (pwm < duty));
         chk1("sclk", bus.sclk, e_sclk);
         chk1("sdi", bus.sdi, e_sdi);
         chk1("latch", bus.latch, e_latch);
         chk1("ready", bus.ready, e_ready);
         chk1("done", bus.done, e_done);
         chk1("noe", bus.n_output_enable, e_noe);
      end
      if (bus.sclk === 1'b1 && sclk_prev === 1'b0) begin
         rises++;
         sdi_sh = {sdi_sh[N-2:0], bus.sdi};
      end
      sclk_prev = bus.sclk;
      if (bus.latch === 1'b1) latches++;
      if (bus.done === 1'b1) dones++;
   endtask

   // Issues one frame and returns the cycle (1 = first after accept) in which done appears.
   task automatic do_frame(input logic [N-1:0] d, input logic [PW-1:0] b, output int lat);
      bus.data       = d;
      bus.brightness = b;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      lat       = 1;
      while (bus.done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic count_low(input int n, output int lows);
      lows = 0;
      repeat (n) begin
         tick();
         if (bus.n_output_enable === 1'b0) lows++;
      end
   endtask

   initial begin
      int            lat, r0, l0, d0, lows, gap;
      logic [N-1:0]  d;
      logic [PW-1:0] b;

      bus.start      = 1'b0;
      bus.data       = '0;
      bus.brightness = '0;

      // reset held three cycles, then idle with no frame
      reset = 1'b1;
      repeat (3) tick();
      chk1("rst_ready", bus.ready, 1'b1);
      chk1("rst_noe", bus.n_output_enable, 1'b1);
      reset = 1'b0;
      count_low(64, lows);
      chkv("idle_noe_lows", lows, 0);

      // frame A5 at half brightness
      r0 = rises; l0 = latches; d0 = dones;
      do_frame(8'hA5, 4'h8, lat);
      chkv("a5_latency", lat, FRAME);
      chkv("a5_pulses", rises - r0, N);
      chkv("a5_bits", 32'(sdi_sh), 32'hA5);
      chkv("a5_latch_cycles", latches - l0, HP);
      chkv("a5_done_count", dones - d0, 1);
      tick();
      count_low(16, lows);
      chkv("duty8_lows", lows, 8);

      // brightness extremes
      do_frame(8'(($urandom)), 4'h0, lat);
      chkv("b0_latency", lat, FRAME);
      tick();
      count_low(32, lows);
      chkv("duty0_lows", lows, 0);
      do_frame(8'(($urandom)), 4'hF, lat);
      chkv("bf_latency", lat, FRAME);
      tick();
      count_low(16, lows);
      chkv("dutyf_lows", lows, 15);

      // start held high, data toggling between frames
      d0 = dones;
      bus.data       = 8'h00;
      bus.brightness = 4'h4;
      bus.start      = 1'b1;
      for (int f = 0; f < 4; f++) begin
         lat = 0;
         do begin
            tick();
            lat++;
         end while (bus.done !== 1'b1 && lat < 100);
         chkv("b2b_gap", lat, FRAME);
         bus.data = ~bus.data;
      end
      bus.start = 1'b0;
      chkv("b2b_done_count", dones - d0, 4);
      chkv("b2b_last_bits", 32'(sdi_sh), 32'hFF);
      tick();

      // start pulse while bit 3 is shifting is ignored
      d = 8'(($urandom));
      r0 = rises; d0 = dones;
      bus.data       = d;
      bus.brightness = 4'h6;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      lat       = 1;
      while (bus.done !== 1'b1 && lat < 100) begin
         bus.start = (lat == 17);
         tick();
         lat++;
      end
      bus.start = 1'b0;
      chkv("ignore_latency", lat, FRAME);
      chkv("ignore_pulses", rises - r0, N);
      chkv("ignore_bits", 32'(sdi_sh), 32'(d));
      tick();
      chkv("ignore_done_count", dones - d0, 1);

      // reset during HIGH of bit 5 aborts the frame
      l0 = latches; d0 = dones;
      bus.data       = 8'h3C;
      bus.brightness = 4'h5;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      lat       = 1;
      while (lat < 11) begin
         tick();
         lat++;
      end
      chk1("pre_rst_sclk", bus.sclk, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk1("abort_sclk", bus.sclk, 1'b0);
      chk1("abort_ready", bus.ready, 1'b1);
      chk1("abort_noe", bus.n_output_enable, 1'b1);
      repeat (40) tick();
      chkv("abort_latch_cycles", latches - l0, 0);
      chkv("abort_done_count", dones - d0, 0);
      do_frame(8'h96, 4'h3, lat);
      chkv("post_abort_latency", lat, FRAME);
      chkv("post_abort_bits", 32'(sdi_sh), 32'h96);
      tick();

      // random frames with random idle gaps
      for (int i = 0; i < 6; i++) begin
         d   = 8'(($urandom));
         b   = 4'(($urandom));
         gap = int'($urandom_range(3, 0));
         repeat (gap) tick();
         r0 = rises;
         do_frame(d, b, lat);
         chkv("rnd_latency", lat, FRAME);
         chkv("rnd_pulses", rises - r0, N);
         chkv("rnd_bits", 32'(sdi_sh), 32'(d));
      end
      tick();
      count_low(16, lows);
      chkv("rnd_duty_lows", lows, int'(b));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_chain_driver.md
LED_CHAIN_DRIVER -- requirements
Module: led_chain_driver

Interface
REQ-001 The block SHALL declare parameter N_BITS, default 16, giving the shift-chain length in bits (range 1..256).
REQ-002 The block SHALL declare parameter HALF_PERIOD, default 2, giving CLOCK_5 cycles per sclk half-period (minimum 1).
REQ-003 The block SHALL declare parameter PWM_BITS, default 8, giving the brightness PWM resolution.
REQ-004 The block SHALL have port CLOCK_5  in  1  system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port start  in  1  frame request, accepted only when ready=1.
REQ-007 The block SHALL have port data  in  N_BITS  frame pattern, captured on accept.
REQ-008 The block SHALL have port brightness  in  PWM_BITS  duty value, captured on accept.
REQ-009 The block SHALL have port ready  out  1  high in IDLE.
REQ-010 The block SHALL have port done  out  1  one-cycle pulse at frame completion.
REQ-011 The block SHALL have ports sdi, sclk, latch and n_output_enable  out  1 each, the serial data, shift clock, latch enable and active-low output enable of the LED driver chain.
REQ-012 The block SHALL have one clock and a synchronous, active-high reset, as already decided.

Function
REQ-013 All outputs SHALL be registered; sclk SHALL NOT be produced by gating CLOCK_5.
REQ-014 The FSM SHALL have states IDLE, SETUP, HIGH and LATCH, with a HALF_PERIOD down-counter and a bit index.
- IDLE: ready=1, sclk=0, sdi=0, latch=0.
- start=1 at an edge while ready=1 -> capture data/brightness into shadow registers, bit index=N_BITS-1, go to SETUP.
- start while ready=0 -> ignored; no queuing.
REQ-015 SETUP SHALL hold sdi=shadow[bit index] with sclk=0 for HALF_PERIOD cycles, then go to HIGH.
REQ-016 HIGH SHALL hold sclk=1 with sdi unchanged for HALF_PERIOD cycles.
- Then: bit index>0 -> decrement the index and go to SETUP; bit index=0 -> go to LATCH.
REQ-017 Bits SHALL shift MSB first (data[N_BITS-1] is the first bit out).
REQ-018 LATCH SHALL drive latch=1, sclk=0 and sdi=0 for HALF_PERIOD cycles.
- On exit: brightness shadow copied to the active duty register, display_valid set to 1, done=1 for one cycle, state=IDLE.
REQ-019 Frame latency SHALL be fixed: done is high exactly (2*N_BITS+1)*HALF_PERIOD cycles after the accepting edge, in the same cycle that ready returns to 1.
REQ-020 start=1 in the done cycle SHALL be accepted, giving back-to-back frames with no idle gap.
REQ-021 A free-running PWM_BITS counter SHALL increment every cycle and wrap from 2^PWM_BITS-1 to 0.
REQ-022 n_output_enable SHALL be 0 only when display_valid=1 and the counter is less than the active duty, otherwise 1.
- Duty 0 -> outputs always off.
- Duty 2^PWM_BITS-1 -> off one cycle per PWM period.
REQ-023 The active duty SHALL change only at LATCH exit, so the PWM keeps running with the old duty during shifting.

Reset
REQ-024 reset=1 at an edge SHALL force, from the next cycle:
- state=IDLE, ready=1, done=0;
- sdi=0, sclk=0, latch=0, n_output_enable=1;
- PWM counter=0, active duty=0, display_valid=0.
REQ-025 reset SHALL override start in the same cycle.
REQ-026 reset mid-frame SHALL abort the frame with no latch pulse and no done pulse.

Verification
REQ-027 The bench SHALL cover the following directed scenarios, all with N_BITS=8, HALF_PERIOD=2, PWM_BITS=4:
- Reset held 3 cycles -> outputs at REQ-024 values; ready=1; n_output_enable=1 for 64 cycles with no start.
- start with data=8'hA5, brightness=4'h8 -> sdi samples on sclk rising edges are 1,0,1,0,0,1,0,1; exactly 8 sclk pulses, each 2 cycles high and 2 cycles low; one 2-cycle latch pulse; done 34 cycles after accept.
- After the previous frame -> n_output_enable low for 8 of every 16 cycles; brightness=0 -> always 1; brightness=4'hF -> low 15 of 16 cycles.
- start held high continuously with data toggling 8'h00/8'hFF -> consecutive frames, accepts 34 cycles apart, done never missed.
- start pulsed at bit 3 of a frame -> ignored; frame and latency unchanged.
- reset asserted during HIGH at bit 5 -> sclk=0 next cycle, no latch pulse, no done pulse, ready=1; next start completes a normal frame.
